// File: rtl/kamacore_stage_id.sv
// Instruction-decode stage: register file with write-through bypass, op decode,
// load-use hazard detection and the ID/EX pipeline register.
module kamacore_stage_id #(
    parameter int CPU_WIDTH  = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [CPU_WIDTH-1:0]  if_instruction,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    input  logic                  flush,
    output logic                  stall_if,
    input  logic                  wb_we,
    input  logic [4:0]            wb_rd,
    input  logic [CPU_WIDTH-1:0]  wb_data,
    output logic                  ex_valid,
    output logic [5:0]            ex_op,
    output logic [4:0]            ex_rd,
    output logic [ADDR_WIDTH-1:0] ex_pc,
    output logic [CPU_WIDTH-1:0]  ex_rs1_val,
    output logic [CPU_WIDTH-1:0]  ex_rs2_val,
    output logic [CPU_WIDTH-1:0]  ex_imm,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_illegal
);

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h10;
    localparam logic [5:0] OP_SW   = 6'h11;
    localparam logic [5:0] OP_BEQ  = 6'h20;

    logic [CPU_WIDTH-1:0] regs [32];

    logic [5:0]           op;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [CPU_WIDTH-1:0] imm;
    logic [CPU_WIDTH-1:0] rs1_val;
    logic [CPU_WIDTH-1:0] rs2_val;
    logic                 uses_rs1;
    logic                 uses_rs2;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 illegal;
    logic                 hazard;
    logic                 bubble;

    assign op  = if_instruction[31:26];
    assign rd  = if_instruction[25:21];
    assign rs1 = if_instruction[20:16];
    assign rs2 = if_instruction[15:11];
    assign imm = {{(CPU_WIDTH-16){if_instruction[15]}}, if_instruction[15:0]};

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        illegal   = 1'b0;
        case (op)
            OP_NOP: ;
            OP_ADD, OP_SUB: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                reg_write = 1'b1;
            end
            OP_ADDI: begin
                uses_rs1  = 1'b1;
                reg_write = 1'b1;
            end
            OP_LW: begin
                uses_rs1  = 1'b1;
                reg_write = 1'b1;
                mem_read  = 1'b1;
            end
            OP_SW: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // A write landing this cycle is forwarded so decode never sees stale data.
    always_comb begin
        rs1_val = regs[rs1];
        rs2_val = regs[rs2];
        if (wb_we && wb_rd == rs1) rs1_val = wb_data;
        if (wb_we && wb_rd == rs2) rs2_val = wb_data;
        if (rs1 == 5'd0) rs1_val = '0;
        if (rs2 == 5'd0) rs2_val = '0;
    end

    assign hazard = ex_valid && ex_mem_read && (ex_rd != 5'd0) && if_valid &&
                    ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));
    assign stall_if = hazard && !flush;
    assign bubble   = flush || hazard || !if_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_we && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || bubble) begin
            ex_valid     <= 1'b0;
            ex_op        <= '0;
            ex_rd        <= '0;
            ex_pc        <= '0;
            ex_rs1_val   <= '0;
            ex_rs2_val   <= '0;
            ex_imm       <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_illegal   <= 1'b0;
        end else begin
            ex_valid     <= 1'b1;
            ex_op        <= op;
            ex_rd        <= rd;
            ex_pc        <= if_pc;
            ex_rs1_val   <= rs1_val;
            ex_rs2_val   <= rs2_val;
            ex_imm       <= imm;
            ex_reg_write <= reg_write;
            ex_mem_read  <= mem_read;
            ex_mem_write <= mem_write;
            ex_illegal   <= illegal;
        end
    end

endmodule

// File: tb/tb_kamacore_stage_id.sv
// Table-driven bench for kamacore_stage_id: each row is one decode cycle; the
// expected ID/EX contents are queued at drive time and compared a cycle later.
module tb_kamacore_stage_id;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [15:0] if_pc;
    logic        flush;
    logic        stall_if;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [5:0]  ex_op;
    logic [4:0]  ex_rd;
    logic [15:0] ex_pc;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic [31:0] ex_imm;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_illegal;

    int checks = 0;
    int failures = 0;

    kamacore_stage_id #(.CPU_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instruction(if_instruction),
        .if_pc(if_pc), .flush(flush), .stall_if(stall_if), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_imm(ex_imm), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [15:0] imm16;
        logic        flush;
        logic        wbwe;
        logic [4:0]  wbrd;
        logic [31:0] wbdata;
        logic        e_stall;
        logic        e_valid;
        logic [5:0]  e_op;
        logic [4:0]  e_rd;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_imm;
        logic [3:0]  e_ctl;
    } vec_t;

    typedef struct {
        int           idx;
        logic [150:0] bits;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mkv(input logic r, input logic iv, input logic [5:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [15:0] imm16, input logic fl, input logic we,
                                 input logic [4:0] wrd, input logic [31:0] wd,
                                 input logic st, input logic v, input logic [5:0] eop,
                                 input logic [4:0] erd, input logic [31:0] e1,
                                 input logic [31:0] e2, input logic [31:0] ei,
                                 input logic [3:0] ctl);
        vec_t t;
        t.rst = r; t.iv = iv; t.op = op; t.rd = rd; t.rs1 = rs1; t.imm16 = imm16;
        t.flush = fl; t.wbwe = we; t.wbrd = wrd; t.wbdata = wd;
        t.e_stall = st; t.e_valid = v; t.e_op = eop; t.e_rd = erd;
        t.e_rs1 = e1; t.e_rs2 = e2; t.e_imm = ei; t.e_ctl = ctl;
        return t;
    endfunction

    function automatic logic [150:0] actual_bits();
        return {ex_valid, ex_op, ex_rd, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
                ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal};
    endfunction

    task automatic apply_stimulus(input vec_t t, input int idx);
        logic [15:0] pc;
        exp_t e;
        pc = 16'h0100 + 16'(idx * 4);
        rst            = t.rst;
        if_valid       = t.iv;
        if_instruction = {t.op, t.rd, t.rs1, t.imm16};
        if_pc          = pc;
        flush          = t.flush;
        wb_we          = t.wbwe;
        wb_rd          = t.wbrd;
        wb_data        = t.wbdata;
        #1;
        checks++;
        if (stall_if !== t.e_stall) begin
            failures++;
            $display("[TB] FAIL stall_vec%0d: got %b want %b", idx, stall_if, t.e_stall);
        end
        e.idx  = idx;
        e.bits = {t.e_valid, t.e_op, t.e_rd, (t.e_valid ? pc : 16'h0), t.e_rs1, t.e_rs2,
                  t.e_imm, t.e_ctl};
        sb.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        logic [150:0] act;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        act = actual_bits();
        checks++;
        if (act !== e.bits) begin
            failures++;
            $display("[TB] FAIL idex_vec%0d: got %h want %h", e.idx, act, e.bits);
        end
    endtask

    initial begin
        rst = 1'b0; if_valid = 1'b0; if_instruction = '0; if_pc = '0;
        flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;

        // ctl = {reg_write, mem_read, mem_write, illegal}
        vecs.push_back(mkv(1,1,6'h08, 1,0,16'h0005, 0,0,0,0,             0,1,6'h08, 1,0,0,32'h5,4'b1000));
        vecs.push_back(mkv(1,0,6'h00, 0,0,16'h0000, 0,1,1,32'h5,         0,0,6'h00, 0,0,0,0,0));
        vecs.push_back(mkv(1,1,6'h01, 2,1,16'h0000, 0,0,0,0,             0,1,6'h01, 2,32'h5,0,0,4'b1000));
        vecs.push_back(mkv(1,1,6'h08, 5,0,16'hFFFF, 0,0,0,0,             0,1,6'h08, 5,0,0,32'hFFFFFFFF,4'b1000));
        vecs.push_back(mkv(1,1,6'h01, 6,3,16'h0000, 0,1,3,32'hDEADBEEF,  0,1,6'h01, 6,32'hDEADBEEF,0,0,4'b1000));
        vecs.push_back(mkv(1,1,6'h01, 7,0,16'h1800, 0,1,0,32'h1234,      0,1,6'h01, 7,0,32'hDEADBEEF,32'h1800,4'b1000));
        vecs.push_back(mkv(1,1,6'h02, 8,1,16'h1800, 0,0,0,0,             0,1,6'h02, 8,32'h5,32'hDEADBEEF,32'h1800,4'b1000));
        vecs.push_back(mkv(1,1,6'h11, 0,1,16'h1800, 0,0,0,0,             0,1,6'h11, 0,32'h5,32'hDEADBEEF,32'h1800,4'b0010));
        vecs.push_back(mkv(1,1,6'h20, 0,3,16'h0800, 0,0,0,0,             0,1,6'h20, 0,32'hDEADBEEF,32'h5,32'h800,4'b0000));
        vecs.push_back(mkv(1,1,6'h3F, 9,0,16'h0000, 0,0,0,0,             0,1,6'h3F, 9,0,0,0,4'b0001));
        vecs.push_back(mkv(1,1,6'h00, 0,0,16'h0000, 0,0,0,0,             0,1,6'h00, 0,0,0,0,4'b0000));
        vecs.push_back(mkv(1,1,6'h08, 1,1,16'h0007, 1,0,0,0,             0,0,6'h00, 0,0,0,0,0));
        // load-use: LW r4 then ADD rs2=4 stalls once and re-issues
        vecs.push_back(mkv(1,1,6'h10, 4,1,16'h0008, 0,0,0,0,             0,1,6'h10, 4,32'h5,0,32'h8,4'b1100));
        vecs.push_back(mkv(1,1,6'h01,10,0,16'h2000, 0,0,0,0,             1,0,6'h00, 0,0,0,0,0));
        vecs.push_back(mkv(1,1,6'h01,10,0,16'h2000, 0,0,0,0,             0,1,6'h01,10,0,0,32'h2000,4'b1000));
        // LW r0 never creates a hazard
        vecs.push_back(mkv(1,1,6'h10, 0,1,16'h0000, 0,0,0,0,             0,1,6'h10, 0,32'h5,0,0,4'b1100));
        vecs.push_back(mkv(1,1,6'h01,11,0,16'h0000, 0,0,0,0,             0,1,6'h01,11,0,0,0,4'b1000));
        // ADDI with rs2 field equal to the load target is not a hazard
        vecs.push_back(mkv(1,1,6'h10, 4,1,16'h0000, 0,0,0,0,             0,1,6'h10, 4,32'h5,0,0,4'b1100));
        vecs.push_back(mkv(1,1,6'h08,12,0,16'h2000, 0,0,0,0,             0,1,6'h08,12,0,0,32'h2000,4'b1000));
        // flush wins over a simultaneous load-use hazard
        vecs.push_back(mkv(1,1,6'h10, 4,1,16'h0000, 0,0,0,0,             0,1,6'h10, 4,32'h5,0,0,4'b1100));
        vecs.push_back(mkv(1,1,6'h01,13,4,16'h0000, 1,0,0,0,             0,0,6'h00, 0,0,0,0,0));
        vecs.push_back(mkv(1,1,6'h01,13,4,16'h0000, 0,0,0,0,             0,1,6'h01,13,0,0,0,4'b1000));
        // reset mid-stream drops the instruction, the wb pulse and r1's value
        vecs.push_back(mkv(0,1,6'h08, 1,0,16'h0005, 0,1,2,32'h55,        0,0,6'h00, 0,0,0,0,0));
        vecs.push_back(mkv(1,1,6'h01,14,1,16'h1000, 0,0,0,0,             0,1,6'h01,14,0,0,32'h1000,4'b1000));

        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (actual_bits() !== '0 || stall_if !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: got %h stall %b want 0", actual_bits(), stall_if);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check_output();
            apply_stimulus(vecs[i], i);
        end
        @(negedge clk);
        check_output();
        if_valid = 1'b0; wb_we = 1'b0; flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
